// File: rtl/vga_wb_sequencer.sv
// vga_wb_sequencer
//   Wishbone initiator that replays a stream of register-write commands into
//   the VGA core register block. Commands (8-bit register offset + 32-bit
//   data) are buffered in a small FIFO and issued one at a time as single
//   Wishbone write cycles. Responders may hold ACK high while STB stays high,
//   or stall ACK for a long time (e.g. a wait-for-condition register), so
//   every bus cycle is followed by a dead GAP cycle in which ACK is ignored.
//
// Parameters
//   FIFO_DEPTH      command FIFO entries (power of 2, >= 2)
//   BASE_HI         value driven on wb_addr_o[31:24]
//   TIMEOUT_CYCLES  max ISSUE cycles to wait for ACK; 0 = wait forever
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_ready is a registered !full
//   cmd_addr/data     register offset and write data
//   wb_addr_o         {BASE_HI, 16'h0000, offset}
//   wb_data_o         write data
//   wb_sel_o          always 4'hF
//   wb_we_o/stb_o/cyc_o  all high together for the duration of a bus cycle
//   wb_ack_i          responder acknowledge (only honoured in ISSUE)
//   busy              FIFO non-empty or a bus cycle / gap in progress
//   err_timeout       sticky flag: a bus cycle was aborted by timeout
//   err_clear         clears err_timeout (a new timeout wins over a clear)
//   done_count        number of acknowledged transactions, wraps at 16 bits

module vga_wb_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [7:0]  BASE_HI        = 8'h04,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clear,
  output logic [15:0] done_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_COUNT   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [23:0]      TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             push, pop;
  logic             ack_hit, timeout_hit;
  logic [23:0]      wait_cnt;

  assign push = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. ACK is only looked at in ISSUE; an ACK arriving in the
  // same cycle the wait counter runs out takes priority over the timeout.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (wb_ack_i) begin
          ack_hit    = 1'b1;
          state_next = GAP;
        end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST)) begin
          timeout_hit = 1'b1;
          state_next  = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + COUNT_ONE;
    else if (!push && pop) count_next = count - COUNT_ONE;
  end

  // FIFO storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  // FIFO control, bus address/data registers, wait counter and status.
  // cmd_ready is computed from the post-edge occupancy so it is registered
  // yet never lets a push through when the FIFO is full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready   <= 1'b1;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wait_cnt    <= '0;
      done_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      count     <= count_next;
      cmd_ready <= (count_next != FULL_COUNT);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        wb_addr_o <= {BASE_HI, 16'h0000, fifo_addr[rd_ptr]};
        wb_data_o <= fifo_data[rd_ptr];
        wait_cnt  <= '0;
      end else if (state == ISSUE) begin
        wait_cnt <= wait_cnt + 24'd1;
      end
      if (ack_hit) done_count <= done_count + 16'd1;
      if (timeout_hit)    err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

  assign wb_stb_o = (state == ISSUE);
  assign wb_cyc_o = wb_stb_o;
  assign wb_we_o  = wb_stb_o;
  assign wb_sel_o = 4'hF;
  assign busy     = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_vga_wb_sequencer.sv
// tb_vga_wb_sequencer
//   Self-checking bench for vga_wb_sequencer (FIFO_DEPTH=8, TIMEOUT_CYCLES=16).
//   A responder process models the Wishbone target (no ACK, ACK pulse after
//   N strobe cycles, or ACK held until STB drops). Accepted commands go into
//   a scoreboard queue; a monitor pops one entry per STB rise and checks the
//   bus address/data, STB high/low run lengths and the control signals.

module tb_vga_wb_sequencer;

  localparam int         DEPTH = 8;
  localparam int         TOUT  = 16;
  localparam logic [7:0] BASE  = 8'h04;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic        err_clear = 1'b0;
  logic [15:0] done_count;

  vga_wb_sequencer #(
    .FIFO_DEPTH    (DEPTH),
    .BASE_HI       (BASE),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .busy       (busy),
    .err_timeout(err_timeout),
    .err_clear  (err_clear),
    .done_count (done_count)
  );

  typedef enum int {RESP_NONE, RESP_PULSE, RESP_HOLD} resp_t;
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  resp_t resp_mode = RESP_NONE;
  int    ack_at = 1;

  cmd_t  sb_q[$];
  cmd_t  cur_cmd;

  int checks_total  = 0;
  int checks_passed = 0;
  int expected_done = 0;

  int issue_cnt     = 0;
  int fall_cnt      = 0;
  int high_run      = 0;
  int low_run       = 0;
  int last_high_len = 0;
  bit stb_prev      = 1'b0;
  bit gap_check     = 1'b0;
  int gap_fall_base = 0;

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at %0t",
                  tag, observed, expected, $time);
  endtask

  // Main-thread time base: just after the falling edge, away from posedge.
  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) waitCycle();
  endtask

  task automatic pushExpected(input logic [7:0] a, input logic [31:0] d);
    cmd_t c;
    c.addr = a;
    c.data = d;
    sb_q.push_back(c);
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d);
    bit accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (cmd_ready) begin
        pushExpected(a, d);
        accepted = 1'b1;
      end
      waitCycle();
    end
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitFalls(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (fall_cnt < target && n < budget) begin
      waitCycle();
      n++;
    end
    if (fall_cnt < target) checkOutput(tag, fall_cnt, target);
  endtask

  // Wishbone target model, updated just after each rising edge.
  initial begin : responder
    int   stb_age;
    bit   stb_was;
    logic ack;
    stb_age = 0;
    stb_was = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_stb_o) stb_age++;
      else          stb_age = 0;
      case (resp_mode)
        RESP_PULSE: ack = wb_stb_o && (stb_age >= ack_at);
        RESP_HOLD:  ack = (wb_stb_o && (stb_age >= ack_at)) || (wb_ack_i && stb_was);
        default:    ack = 1'b0;
      endcase
      stb_was  = wb_stb_o;
      wb_ack_i = ack;
    end
  end

  // Bus monitor: pops the scoreboard on every STB rise and checks each cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (wb_stb_o && !stb_prev) begin
        issue_cnt++;
        high_run = 0;
        if (gap_check && fall_cnt > gap_fall_base)
          checkOutput("stb_low_gap", low_run, 2);
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_issue", 32'd1, 32'd0);
          cur_cmd = '0;
        end else begin
          cur_cmd = sb_q.pop_front();
        end
      end
      if (!wb_stb_o && stb_prev) begin
        fall_cnt++;
        last_high_len = high_run;
        low_run = 0;
      end
      if (wb_stb_o) begin
        high_run++;
        checkOutput("wb_addr", wb_addr_o, {BASE, 16'h0000, cur_cmd.addr});
        checkOutput("wb_data", wb_data_o, cur_cmd.data);
        checkOutput("wb_ctrl_active", {26'd0, wb_cyc_o, wb_we_o, wb_sel_o}, 32'h3F);
      end else begin
        low_run++;
        checkOutput("wb_ctrl_idle", {26'd0, wb_cyc_o, wb_we_o, wb_sel_o}, 32'h0F);
      end
      stb_prev = wb_stb_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: observed no completion, expected summary before 500000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int fb;
    int acc;

    // Reset values.
    waitCycles(3);
    checkOutput("rst_addr", wb_addr_o, 32'h0);
    checkOutput("rst_data", wb_data_o, 32'h0);
    checkOutput("rst_stb", 32'(wb_stb_o), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done_count), 0);
    checkOutput("rst_err", 32'(err_timeout), 0);
    reset = 1'b0;
    waitCycle();
    checkOutput("post_rst_ready", 32'(cmd_ready), 1);

    // Single command, ACK in the third strobe cycle.
    $display("[TB] single command");
    resp_mode = RESP_PULSE;
    ack_at    = 3;
    fb        = fall_cnt;
    applyStimulus(8'h08, 32'h0040_0000);
    checkOutput("t1_stb_after_push", 32'(wb_stb_o), 0);
    checkOutput("t1_busy_queued", 32'(busy), 1);
    waitCycle();
    checkOutput("t1_stb_rise", 32'(wb_stb_o), 1);
    checkOutput("t1_addr", wb_addr_o, 32'h0400_0008);
    waitFalls(fb + 1, 50, "t1_ack_wait");
    checkOutput("t1_stb_len", last_high_len, 3);
    waitCycles(1);
    expected_done = 1;
    checkOutput("t1_done", 32'(done_count), expected_done);
    checkOutput("t1_busy_idle", 32'(busy), 0);

    // Fill with ACK withheld: 8 queued + 1 in flight, then release.
    $display("[TB] fifo fill");
    resp_mode = RESP_NONE;
    fb        = fall_cnt;
    acc       = 0;
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'h20 + 8'(acc);
      cmd_data  = 32'hA500_0000 + 32'(acc);
      if (cmd_ready) begin
        pushExpected(cmd_addr, cmd_data);
        acc++;
      end
      waitCycle();
    end
    checkOutput("t2_accepted", acc, DEPTH + 1);
    checkOutput("t2_ready_full", 32'(cmd_ready), 0);
    checkOutput("t2_busy_full", 32'(busy), 1);
    resp_mode = RESP_PULSE;
    ack_at    = 1;
    for (int i = 0; i < 60 && acc < DEPTH + 2; i++) begin
      if (cmd_ready) begin
        pushExpected(cmd_addr, cmd_data);
        acc++;
      end
      waitCycle();
    end
    cmd_valid = 1'b0;
    checkOutput("t2_tenth_accepted", acc, DEPTH + 2);
    waitFalls(fb + DEPTH + 2, 400, "t2_drain");
    waitCycles(2);
    expected_done += DEPTH + 2;
    checkOutput("t2_done", 32'(done_count), expected_done);
    checkOutput("t2_busy_idle", 32'(busy), 0);

    // Responder holds ACK until STB drops; no double counting, 2-cycle gaps.
    $display("[TB] held ack");
    resp_mode     = RESP_HOLD;
    ack_at        = 2;
    fb            = fall_cnt;
    gap_fall_base = fb;
    gap_check     = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(8'h40 + 8'(i), 32'hC0DE_0000 + 32'(i));
    waitFalls(fb + 4, 200, "t3_drain");
    gap_check = 1'b0;
    waitCycles(2);
    expected_done += 4;
    checkOutput("t3_done", 32'(done_count), expected_done);
    checkOutput("t3_busy_idle", 32'(busy), 0);

    // Timeout with no ACK, then next command acked on the final cycle.
    $display("[TB] timeout");
    resp_mode = RESP_NONE;
    fb        = fall_cnt;
    applyStimulus(8'h18, 32'h0000_0001);
    applyStimulus(8'h10, 32'h1234_5678);
    waitFalls(fb + 1, 60, "t4_timeout_wait");
    checkOutput("t4_stb_len", last_high_len, TOUT);
    checkOutput("t4_err_set", 32'(err_timeout), 1);
    checkOutput("t4_done", 32'(done_count), expected_done);
    err_clear = 1'b1;
    resp_mode = RESP_PULSE;
    ack_at    = TOUT;
    waitCycle();
    err_clear = 1'b0;
    checkOutput("t4_err_cleared", 32'(err_timeout), 0);
    waitFalls(fb + 2, 60, "t5_ack_wait");
    checkOutput("t5_stb_len", last_high_len, TOUT);
    checkOutput("t5_err_still_clear", 32'(err_timeout), 0);
    waitCycles(1);
    expected_done += 1;
    checkOutput("t5_done", 32'(done_count), expected_done);

    // Timeout while err_clear is held: the set wins.
    $display("[TB] set over clear");
    resp_mode = RESP_NONE;
    fb        = fall_cnt;
    err_clear = 1'b1;
    applyStimulus(8'h1C, 32'hDEAD_BEEF);
    waitFalls(fb + 1, 60, "t4b_timeout_wait");
    checkOutput("t4b_err_set_wins", 32'(err_timeout), 1);
    err_clear = 1'b0;
    waitCycle();
    checkOutput("t4b_err_sticky", 32'(err_timeout), 1);
    checkOutput("t4b_done", 32'(done_count), expected_done);

    // Reset mid-ISSUE with three commands queued.
    $display("[TB] reset mid-cycle");
    for (int i = 0; i < 4; i++)
      applyStimulus(8'h50 + 8'(i), 32'h5A5A_0000 + 32'(i));
    waitCycles(2);
    checkOutput("t6_pre_stb", 32'(wb_stb_o), 1);
    checkOutput("t6_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    waitCycle();
    checkOutput("t6_stb", 32'(wb_stb_o), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_done", 32'(done_count), 0);
    checkOutput("t6_ready", 32'(cmd_ready), 1);
    checkOutput("t6_err", 32'(err_timeout), 0);
    checkOutput("t6_addr", wb_addr_o, 32'h0);
    sb_q.delete();
    expected_done = 0;
    reset     = 1'b0;
    resp_mode = RESP_PULSE;
    ack_at    = 1;
    for (int i = 0; i < 20; i++) begin
      waitCycle();
      checkOutput("t6_no_replay", {30'd0, wb_stb_o, busy}, 32'h0);
    end

    // Normal operation resumes after reset.
    $display("[TB] post-reset command");
    fb = fall_cnt;
    applyStimulus(8'h00, 32'h0000_00FF);
    waitFalls(fb + 1, 50, "t7_ack_wait");
    waitCycles(1);
    expected_done += 1;
    checkOutput("t7_done", 32'(done_count), expected_done);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
